// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Free-running raster timing generator. It runs a horizontal pixel counter and
// a vertical line counter, and it produces blanking and sync flags that line
// up with the counts. It also produces a start-of-frame pulse and a
// completed-frame counter.
//
// Ports
//   clk          in   pixel clock. All logic runs on the rising edge.
//   rst          in   synchronous reset, active low.
//   hcount[10:0] out  pixel index within the line, 0..HOR_TOTAL-1.
//   hsync        out  horizontal sync, active high.
//   hblnk        out  horizontal blanking.
//   vcount[10:0] out  line index within the frame, 0..VER_TOTAL-1.
//   vsync        out  vertical sync, active high.
//   vblnk        out  vertical blanking.
//   frame_start  out  one-cycle pulse while pixel (0,0) is presented.
//   frame_cnt    out  number of frames completed since reset. Wraps at 16 bits.
// The hcount/hsync/hblnk/vcount/vsync/vblnk signals together form the timing
// bundle that feeds the draw chain.
module vga_timing_gen #(
  parameter int HOR_TOTAL       = 1056,
  parameter int HOR_BLANK_START = 800,
  parameter int HOR_SYNC_START  = 840,
  parameter int HOR_SYNC_END    = 968,
  parameter int VER_TOTAL       = 628,
  parameter int VER_BLANK_START = 600,
  parameter int VER_SYNC_START  = 601,
  parameter int VER_SYNC_END    = 605
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  // The comparisons use 12 bits so that a sync end equal to 2048 still works.
  localparam logic [11:0] H_LAST   = 12'(HOR_TOTAL - 1);
  localparam logic [11:0] H_BLANK  = 12'(HOR_BLANK_START);
  localparam logic [11:0] H_SYNC_S = 12'(HOR_SYNC_START);
  localparam logic [11:0] H_SYNC_E = 12'(HOR_SYNC_END);
  localparam logic [11:0] V_LAST   = 12'(VER_TOTAL - 1);
  localparam logic [11:0] V_BLANK  = 12'(VER_BLANK_START);
  localparam logic [11:0] V_SYNC_S = 12'(VER_SYNC_START);
  localparam logic [11:0] V_SYNC_E = 12'(VER_SYNC_END);

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic [11:0] h_next_w;
  logic [11:0] v_next_w;

  always_comb begin
    h_wrap = ({1'b0, hcount} == H_LAST);
    v_wrap = ({1'b0, vcount} == V_LAST);
    h_next = h_wrap ? '0 : hcount + 11'd1;
    v_next = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + 11'd1;
    end
    h_next_w = {1'b0, h_next};
    v_next_w = {1'b0, v_next};
  end

  // The flags are decoded from the next counter values. As a result, each flag
  // is registered at the same edge as the count it describes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= (h_next_w >= H_BLANK);
      hsync       <= (h_next_w >= H_SYNC_S) && (h_next_w < H_SYNC_E);
      vblnk       <= (v_next_w >= V_BLANK);
      vsync       <= (v_next_w >= V_SYNC_S) && (v_next_w < V_SYNC_E);
      frame_start <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// This bench checks vga_timing_gen with a small raster geometry. The reference
// model counts the clock edges since the last reset release. It then derives
// every expected output from that count with division and modulo.
module tb_vga_timing_gen;

  localparam int HT  = 20;
  localparam int HB  = 12;
  localparam int HSS = 14;
  localparam int HSE = 17;
  localparam int VT  = 10;
  localparam int VB  = 7;
  localparam int VSS = 8;
  localparam int VSE = 10;
  localparam int FT  = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic        frame_start;
  logic [15:0] frame_cnt;

  vga_timing_gen #(
    .HOR_TOTAL      (HT),
    .HOR_BLANK_START(HB),
    .HOR_SYNC_START (HSS),
    .HOR_SYNC_END   (HSE),
    .VER_TOTAL      (VT),
    .VER_BLANK_START(VB),
    .VER_SYNC_START (VSS),
    .VER_SYNC_END   (VSE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .hsync      (hsync),
    .hblnk      (hblnk),
    .vcount     (vcount),
    .vsync      (vsync),
    .vblnk      (vblnk),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model state: t is the number of edges since the reset was released.
  int t       = 0;
  bit in_rst  = 1'b1;
  bit started = 1'b0;
  int fc_base = 0;

  // Event tallies for the literal checks. The stimulus clears them.
  int n_fs = 0, n_hs = 0, n_vs = 0, n_hb = 0, n_vb = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst) begin
      in_rst  = 1'b1;
      t       = 0;
      fc_base = 0;
    end else begin
      in_rst = 1'b0;
      t++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      int h, v;
      bit e_hb, e_hs, e_vb, e_vs, e_fs;
      logic [15:0] e_fc;
      h    = t % HT;
      v    = (t / HT) % VT;
      e_hb = !in_rst && (h >= HB);
      e_hs = !in_rst && (h >= HSS) && (h < HSE);
      e_vb = !in_rst && (v >= VB);
      e_vs = !in_rst && (v >= VSS) && (v < VSE);
      e_fs = !in_rst && (t > 0) && (t % FT == 0);
      e_fc = in_rst ? 16'd0 : 16'((fc_base + t / FT) & 32'hFFFF);
      check("hcount", 16'(hcount), in_rst ? 16'd0 : 16'(h));
      check("vcount", 16'(vcount), in_rst ? 16'd0 : 16'(v));
      check("hblnk", 16'(hblnk), 16'(e_hb));
      check("hsync", 16'(hsync), 16'(e_hs));
      check("vblnk", 16'(vblnk), 16'(e_vb));
      check("vsync", 16'(vsync), 16'(e_vs));
      check("frame_start", 16'(frame_start), 16'(e_fs));
      check("frame_cnt", frame_cnt, e_fc);
      if (!in_rst) begin
        if (frame_start) n_fs++;
        if (hsync) n_hs++;
        if (vsync) n_vs++;
        if (hblnk) n_hb++;
        if (vblnk) n_vb++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bit got;
    rst = 1'b0;
    step(3);
    check("rst_hcount", 16'(hcount), 16'd0);
    check("rst_frame_start", 16'(frame_start), 16'd0);

    // Release the reset. The first edge must present (1,0).
    rst = 1'b1;
    n_fs = 0; n_hs = 0; n_vs = 0; n_hb = 0; n_vb = 0;
    step(1);
    check("rel_hcount", 16'(hcount), 16'd1);
    check("rel_vcount", 16'(vcount), 16'd0);
    step(HT - 1);
    check("wrap_hcount", 16'(hcount), 16'd0);
    check("wrap_vcount", 16'(vcount), 16'd1);

    // Run three full frames. Take the tallies just after the negedge sample of t=600.
    step(3 * FT - HT);
    @(negedge clk); #1;
    check("three_frames_cnt", frame_cnt, 16'd3);
    check("three_frames_pulses", 16'(n_fs), 16'd3);
    check("hsync_cycles", 16'(n_hs), 16'd90);   // 3 frames * 10 lines * 3 px
    check("vsync_cycles", 16'(n_vs), 16'd120);  // 3 frames * 2 lines * 20 px
    check("hblnk_cycles", 16'(n_hb), 16'd240);  // 3 frames * 10 lines * 8 px
    check("vblnk_cycles", 16'(n_vb), 16'd180);  // 3 frames * 3 lines * 20 px

    // Assert the reset in the middle of a frame for one cycle.
    step($urandom_range(FT / 3, FT));
    rst = 1'b0;
    step(1);
    check("mid_rst_hcount", 16'(hcount), 16'd0);
    check("mid_rst_hsync", 16'(hsync), 16'd0);
    check("mid_rst_cnt", frame_cnt, 16'd0);
    rst = 1'b1;
    step(1);
    check("mid_rel_hcount", 16'(hcount), 16'd1);
    check("mid_rel_vcount", 16'(vcount), 16'd0);
    check("mid_rel_cnt", frame_cnt, 16'd0);

    // Random run lengths with occasional reset pulses of random length.
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(1, 3 * FT));
      if ($urandom_range(0, 2) == 0) begin
        rst = 1'b0;
        step($urandom_range(1, 3));
        rst = 1'b1;
      end
    end

    // Preload the frame counter at its maximum value. The next frame wrap must
    // take it to 0.
    step($urandom_range(1, FT));
    force dut.frame_cnt = 16'hFFFF;
    fc_base = 65535 - t / FT;
    #1 release dut.frame_cnt;
    got = 1'b0;
    for (int i = 0; i < FT + 2 && !got; i++) begin
      step(1);
      if (frame_start) got = 1'b1;
    end
    check("cnt_wrap_seen", 16'(got), 16'd1);
    check("cnt_wrap_value", frame_cnt, 16'd0);
    step(FT + 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter HOR_TOTAL, default 1056, pixels per line (hcount range 0..HOR_TOTAL-1).
REQ-002 Parameter HOR_BLANK_START, default 800, first blanked pixel; blanking lasts to end of line.
REQ-003 Parameter HOR_SYNC_START, default 840, first hsync pixel.
REQ-004 Parameter HOR_SYNC_END, default 968, first pixel after hsync (exclusive).
REQ-005 Parameter VER_TOTAL, default 628, lines per frame (vcount range 0..VER_TOTAL-1).
REQ-006 Parameter VER_BLANK_START, default 600, first blanked line; blanking lasts to end of frame.
REQ-007 Parameter VER_SYNC_START, default 601, first vsync line.
REQ-008 Parameter VER_SYNC_END, default 605, first line after vsync (exclusive).
REQ-009 clk  input  1  pixel clock, 40 MHz; all logic on rising edge.
REQ-010 rst  input  1  synchronous reset, active-low: logic resets on a rising clk edge while rst is 0.
REQ-011 tim_if  vga_if_tim.out  bundle  timing output: hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk; feeds the start-screen draw chain.
REQ-012 frame_start  output  1  single-cycle pulse marking pixel (0,0) of every frame.
REQ-013 frame_cnt  output  16  count of completed frames since reset.

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 hcount SHALL increment by 1 each cycle and wrap from HOR_TOTAL-1 to 0.
REQ-016 vcount SHALL increment by 1 only in the cycle where hcount wraps, and wrap from VER_TOTAL-1 to 0 at the same edge hcount wraps.
REQ-017 hblnk SHALL be 1 exactly when HOR_BLANK_START <= hcount <= HOR_TOTAL-1, evaluated on the hcount value presented in the same cycle.
REQ-018 hsync SHALL be 1 exactly when HOR_SYNC_START <= hcount < HOR_SYNC_END (positive polarity), same-cycle alignment.
REQ-019 vblnk SHALL be 1 exactly when VER_BLANK_START <= vcount <= VER_TOTAL-1 for the entire line, same-cycle alignment.
REQ-020 vsync SHALL be 1 exactly when VER_SYNC_START <= vcount < VER_SYNC_END for the entire line (positive polarity).
REQ-021 Sync/blank flags SHALL be computed from next-state counter values so that flags and counts change at the same clk edge (zero relative skew).
REQ-022 frame_start SHALL be 1 in exactly the cycles where hcount=0 and vcount=0 are presented, except the first cycle after reset release.
REQ-023 frame_cnt SHALL increment by 1 at the edge where both counters wrap to 0; 16-bit unsigned, wraps 65535 -> 0 silently.
REQ-024 Counter widths SHALL be 11 bits; parameters SHALL satisfy HOR_BLANK_START < HOR_SYNC_START < HOR_SYNC_END <= HOR_TOTAL <= 2048, same ordering vertically; violation is a configuration error, behaviour undefined.
REQ-025 Block SHALL run free; no enable, stall or handshake input exists.

Reset
REQ-026 While rst=0 at a clk edge: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0, frame_cnt=0.
REQ-027 First edge with rst=1 SHALL present hcount=1, vcount=0; counting continues normally thereafter.
REQ-028 Reset asserted mid-frame SHALL take effect at the next edge regardless of counter state; no partial-line completion.

Verification
REQ-029 Release reset, run 1056 cycles -> hcount sequence 1..1055,0; vcount goes 0 -> 1 at the edge hcount wraps to 0.
REQ-030 Sample line 0 -> hblnk=1 for hcount 800..1055 only; hsync=1 for hcount 840..967 only (128 cycles); vsync=0, vblnk=0.
REQ-031 Run one full frame (1056*628 = 663168 cycles) -> vblnk=1 for lines 600..627, vsync=1 for lines 601..604 only; vcount wraps 627 -> 0 with hcount 1055 -> 0.
REQ-032 Run 3 frames from reset -> frame_start pulses exactly 3 times, each 1 cycle, at (0,0); frame_cnt reads 3 after the third wrap.
REQ-033 Assert rst=0 at hcount=500, vcount=300 for 1 cycle -> all outputs 0 at next edge, then hcount=1, vcount=0, frame_cnt=0.
REQ-034 Force frame_cnt preload scenario via long run or hierarchical force to 65535, complete a frame -> frame_cnt=0, no other output disturbed.
